// File: rtl/bus_pkg.sv
// Shared bus-source definitions: source codes as seen by both the encoder and
// the decoder, plus the decoder FSM state encoding.
package bus_pkg;

  localparam int NUM_SRC = 24;
  localparam int CODE_W  = 5;

  localparam logic [CODE_W-1:0] SRC_R0    = 5'd0;
  localparam logic [CODE_W-1:0] SRC_R1    = 5'd1;
  localparam logic [CODE_W-1:0] SRC_R2    = 5'd2;
  localparam logic [CODE_W-1:0] SRC_R3    = 5'd3;
  localparam logic [CODE_W-1:0] SRC_R4    = 5'd4;
  localparam logic [CODE_W-1:0] SRC_R5    = 5'd5;
  localparam logic [CODE_W-1:0] SRC_R6    = 5'd6;
  localparam logic [CODE_W-1:0] SRC_R7    = 5'd7;
  localparam logic [CODE_W-1:0] SRC_R8    = 5'd8;
  localparam logic [CODE_W-1:0] SRC_R9    = 5'd9;
  localparam logic [CODE_W-1:0] SRC_R10   = 5'd10;
  localparam logic [CODE_W-1:0] SRC_R11   = 5'd11;
  localparam logic [CODE_W-1:0] SRC_R12   = 5'd12;
  localparam logic [CODE_W-1:0] SRC_R13   = 5'd13;
  localparam logic [CODE_W-1:0] SRC_R14   = 5'd14;
  localparam logic [CODE_W-1:0] SRC_R15   = 5'd15;
  localparam logic [CODE_W-1:0] SRC_HI    = 5'd16;
  localparam logic [CODE_W-1:0] SRC_LO    = 5'd17;
  localparam logic [CODE_W-1:0] SRC_ZHIGH = 5'd18;
  localparam logic [CODE_W-1:0] SRC_ZLOW  = 5'd19;
  localparam logic [CODE_W-1:0] SRC_PC    = 5'd20;
  localparam logic [CODE_W-1:0] SRC_MDR   = 5'd21;
  localparam logic [CODE_W-1:0] SRC_PORT  = 5'd22;
  localparam logic [CODE_W-1:0] SRC_C     = 5'd23;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GAP   = 2'd1,
    DRIVE = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_dec.sv
// Combinational source-code decoder: 5-bit code to one-hot source enables.
// valid is high only for codes that name a real source.
module onehot_dec
  import bus_pkg::*;
(
  input  logic [CODE_W-1:0]  code,
  output logic [NUM_SRC-1:0] onehot,
  output logic               valid
);

  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      onehot[k] = (code == CODE_W'(k));
    end
    // Codes past the last source match no bit, so an empty vector means invalid.
    valid = |onehot;
  end

endmodule

// File: rtl/bus_source_decoder.sv
// Registered bus-source decoder with break-before-make dead time between
// source switches and rejection of out-of-range codes.
module bus_source_decoder
  import bus_pkg::*;
#(
  parameter int GAP_CYCLES = 1
)(
  input  logic               clk,
  input  logic               reset,
  input  logic [CODE_W-1:0]  S,
  input  logic               S_valid,
  output logic [NUM_SRC-1:0] en,
  output logic [CODE_W-1:0]  cur_code,
  output logic               drive,
  output logic               busy,
  output logic               bad_code
);

  // GAP_CYCLES is expected in 1..15; the counter runs from GAP_CYCLES-1 down to 0.
  localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES - 1);

  state_t               state_q, state_d;
  logic [CODE_W-1:0]    cur_q, cur_d;
  logic [CODE_W-1:0]    pend_q, pend_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 bad_d;
  logic [NUM_SRC-1:0]   en_d;

  logic [NUM_SRC-1:0]   req_onehot;
  logic                 req_ok;
  logic [NUM_SRC-1:0]   cur_onehot;
  logic                 cur_ok;
  logic                 same_src;

  onehot_dec u_req_dec (
    .code   (S),
    .onehot (req_onehot),
    .valid  (req_ok)
  );

  onehot_dec u_en_dec (
    .code   (cur_d),
    .onehot (cur_onehot),
    .valid  (cur_ok)
  );

  // While driving, en is onehot(cur_code), so overlap with the request means same source.
  assign same_src = |(req_onehot & en);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    bad_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (S_valid) begin
          if (req_ok) begin
            state_d = DRIVE;
            cur_d   = S;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (!S_valid) begin
          state_d = IDLE;
        end else if (!req_ok) begin
          state_d = IDLE;
          bad_d   = 1'b1;
        end else if (!same_src) begin
          state_d = GAP;
          pend_d  = S;
          cnt_d   = GAP_INIT;
        end
      end
      GAP: begin
        if (S_valid) begin
          if (req_ok) pend_d = S;
          else        bad_d  = 1'b1;
        end
        // A valid request on the last dead cycle is honoured directly.
        if (cnt_q == 4'd0) begin
          state_d = DRIVE;
          cur_d   = pend_d;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    en_d = '0;
    if (state_d == DRIVE && cur_ok) en_d = cur_onehot;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cur_q    <= '0;
      pend_q   <= '0;
      cnt_q    <= '0;
      en       <= '0;
      drive    <= 1'b0;
      busy     <= 1'b0;
      bad_code <= 1'b0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      en       <= en_d;
      drive    <= |en_d;
      busy     <= (state_d == GAP);
      bad_code <= bad_d;
    end
  end

  assign cur_code = cur_q;

endmodule
